// File: rtl/matrix_out_serializer_pkg.sv
// Shared linear-algebra definitions: element widths of the upstream adder
// results and index-width helpers used by the matrix serializer.
package matrix_out_serializer_pkg;

    // An adder of two IN_WIDTH operands produces one extra bit of headroom.
    function automatic int elemWidth(input int inWidth);
        return inWidth + 1;
    endfunction

    function automatic int idxWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    function automatic bank_e otherBank(input bank_e b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/matrix_out_serializer_if.sv
// Matrix capture / element stream bundle between the adder array, the
// serializer and the downstream element consumer.
interface matrix_out_serializer_if #(
    parameter int IN_WIDTH = 16,
    parameter int N        = 10,
    parameter int V        = 10
) ();
    import matrix_out_serializer_pkg::*;

    localparam int EW  = elemWidth(IN_WIDTH);
    localparam int EIW = idxWidth(N);
    localparam int VIW = idxWidth(V);

    logic                  inReady;
    logic                  vectorSetNo;
    logic [N*V*EW-1:0]     sumIn;
    logic                  inFull;
    logic                  overflow;
    logic                  outValid;
    logic                  outReady;
    logic signed [EW-1:0]  outData;
    logic [EIW-1:0]        outElem;
    logic [VIW-1:0]        outVec;
    logic                  outLast;
    logic                  outSetNo;

    modport master (
        output inReady, vectorSetNo, sumIn, outReady,
        input  inFull, overflow, outValid, outData, outElem, outVec, outLast, outSetNo
    );

    modport slave (
        input  inReady, vectorSetNo, sumIn, outReady,
        output inFull, overflow, outValid, outData, outElem, outVec, outLast, outSetNo
    );
endinterface

// File: rtl/matrix_out_serializer_bank.sv
// One N*V-element matrix store: the whole matrix and its set tag are written
// in a single cycle, one element is read combinationally by (elem, vec).
module matrix_bank
    import matrix_out_serializer_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int N        = 10,
    parameter int V        = 10
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [N*V*elemWidth(IN_WIDTH)-1:0]    wrData,
    input  logic                                  wrTag,
    input  logic [idxWidth(N)-1:0]                rdElem,
    input  logic [idxWidth(V)-1:0]                rdVec,
    output logic signed [elemWidth(IN_WIDTH)-1:0] rdData,
    output logic                                  rdTag
);
    localparam int EW = elemWidth(IN_WIDTH);
    localparam int AW = idxWidth(N * V);

    logic signed [EW-1:0] mem [N*V];
    logic                 tagReg;
    logic [AW-1:0]        rdAddr;

    // Contents are deliberately not reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N * V; k++) begin
                mem[k] <= wrData[k*EW +: EW];
            end
            tagReg <= wrTag;
        end
    end

    assign rdAddr = AW'(rdVec) * AW'(N) + AW'(rdElem);
    assign rdData = mem[rdAddr];
    assign rdTag  = tagReg;

endmodule

// File: rtl/matrix_out_serializer.sv
// Ping-pong buffer that captures whole matrices from the adder array and
// streams them out one element at a time, i fastest, with backpressure.
module matrix_out_serializer
    import matrix_out_serializer_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int N        = 10,
    parameter int V        = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    matrix_out_serializer_if.slave   bus
);
    localparam int EW  = elemWidth(IN_WIDTH);
    localparam int EIW = idxWidth(N);
    localparam int VIW = idxWidth(V);

    logic [1:0]     countReg,    countNext;
    bank_e          wrPtrReg,    wrPtrNext;
    bank_e          rdPtrReg,    rdPtrNext;
    logic [EIW-1:0] elemReg,     elemNext;
    logic [VIW-1:0] vecReg,      vecNext;
    logic           overflowReg, overflowNext;

    logic hasData, lastElem, xfer, finalXfer, capture, drop;

    logic signed [EW-1:0] bankData [2];
    logic                 bankTag  [2];
    logic [1:0]           bankWe;

    assign hasData   = (countReg != 2'd0);
    assign lastElem  = (elemReg == EIW'(N - 1)) && (vecReg == VIW'(V - 1));
    assign xfer      = enable && hasData && bus.outReady;
    assign finalXfer = xfer && lastElem;
    // A bank freed on this same edge makes room, so a full buffer still accepts.
    assign capture   = enable && bus.inReady && ((countReg != 2'd2) || finalXfer);
    assign drop      = enable && bus.inReady && (countReg == 2'd2) && !finalXfer;

    always_comb begin
        countNext    = countReg;
        wrPtrNext    = wrPtrReg;
        rdPtrNext    = rdPtrReg;
        elemNext     = elemReg;
        vecNext      = vecReg;
        overflowNext = overflowReg;

        if (capture) begin
            wrPtrNext = otherBank(wrPtrReg);
        end

        if (xfer) begin
            if (lastElem) begin
                elemNext  = '0;
                vecNext   = '0;
                rdPtrNext = otherBank(rdPtrReg);
            end else if (elemReg == EIW'(N - 1)) begin
                elemNext = '0;
                vecNext  = vecReg + VIW'(1);
            end else begin
                elemNext = elemReg + EIW'(1);
            end
        end

        case ({capture, finalXfer})
            2'b10:   countNext = countReg + 2'd1;
            2'b01:   countNext = countReg - 2'd1;
            default: countNext = countReg;
        endcase

        if (drop) begin
            overflowNext = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countReg    <= 2'd0;
            wrPtrReg    <= BANK0;
            rdPtrReg    <= BANK0;
            elemReg     <= '0;
            vecReg      <= '0;
            overflowReg <= 1'b0;
        end else begin
            countReg    <= countNext;
            wrPtrReg    <= wrPtrNext;
            rdPtrReg    <= rdPtrNext;
            elemReg     <= elemNext;
            vecReg      <= vecNext;
            overflowReg <= overflowNext;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bankWe[gi] = capture && (wrPtrReg == bank_e'(1'(gi)));

            matrix_bank #(
                .IN_WIDTH (IN_WIDTH),
                .N        (N),
                .V        (V)
            ) u_bank (
                .clk    (clk),
                .we     (bankWe[gi]),
                .wrData (bus.sumIn),
                .wrTag  (bus.vectorSetNo),
                .rdElem (elemReg),
                .rdVec  (vecReg),
                .rdData (bankData[gi]),
                .rdTag  (bankTag[gi])
            );
        end
    endgenerate

    assign bus.inFull   = (countReg == 2'd2);
    assign bus.overflow = overflowReg;
    assign bus.outValid = hasData;
    assign bus.outData  = bankData[rdPtrReg];
    assign bus.outSetNo = bankTag[rdPtrReg];
    assign bus.outElem  = elemReg;
    assign bus.outVec   = vecReg;
    assign bus.outLast  = hasData && lastElem;

endmodule

// File: tb/tb_matrix_out_serializer.sv
// Scoreboard bench for matrix_out_serializer: stimulus pushes expected
// elements, a negedge monitor compares whatever the DUT presents.
module tb_matrix_out_serializer;
    localparam int IN_WIDTH = 16;
    localparam int N        = 10;
    localparam int V        = 10;
    localparam int EW       = IN_WIDTH + 1;
    localparam int EIW      = 4;
    localparam int VIW      = 4;

    typedef struct packed {
        logic signed [EW-1:0] data;
        logic [EIW-1:0]       elem;
        logic [VIW-1:0]       vec;
        logic                 last;
        logic                 setNo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    matrix_out_serializer_if #(.IN_WIDTH(IN_WIDTH), .N(N), .V(V)) bus ();

    matrix_out_serializer #(.IN_WIDTH(IN_WIDTH), .N(N), .V(V)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    exp_t sbQ[$];
    int   total   = 0;
    int   bad     = 0;
    int   curMode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // mode 0: 10*v+i, mode 1: -(v*N+i), mode 2: 1000*k + v*N+i (k tags each matrix)
    function automatic int expVal(input int mode, input int k, input int i, input int v);
        case (mode)
            0:       return 10 * v + i;
            1:       return -(v * N + i);
            default: return 1000 * k + v * N + i;
        endcase
    endfunction

    function automatic logic [N*V*EW-1:0] buildMatrix(input int mode, input int k);
        logic [N*V*EW-1:0] m;
        m = '0;
        for (int v = 0; v < V; v++)
            for (int i = 0; i < N; i++)
                m[(v*N+i)*EW +: EW] = EW'(expVal(mode, k, i, v));
        return m;
    endfunction

    task automatic pushMatrix(input int mode, input int k, input logic tag);
        exp_t e;
        for (int v = 0; v < V; v++) begin
            for (int i = 0; i < N; i++) begin
                e.data  = EW'(expVal(mode, k, i, v));
                e.elem  = EIW'(i);
                e.vec   = VIW'(v);
                e.last  = (i == N - 1) && (v == V - 1);
                e.setNo = tag;
                sbQ.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendMatrix(input int mode, input int k, input logic tag, input bit accept);
        bus.sumIn       = buildMatrix(mode, k);
        bus.vectorSetNo = tag;
        bus.inReady     = 1'b1;
        if (accept) pushMatrix(mode, k, tag);
        tick();
        bus.inReady = 1'b0;
    endtask

    task automatic drain(input bit backpressure);
        int c = 0;
        while (!(sbQ.size() == 0 && !bus.outValid)) begin
            if (c >= 1000) begin
                total++;
                bad++;
                $display("FAIL drain timeout actual=%0d_left required=0", sbQ.size());
                break;
            end
            if (backpressure) bus.outReady = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
            c++;
        end
    endtask

    // Monitor: every presented element must match the scoreboard head;
    // the head is consumed only when the coming edge is a transfer.
    always @(negedge clk) begin
        exp_t act;
        if (!reset && bus.outValid) begin
            act = {bus.outData, bus.outElem, bus.outVec, bus.outLast, bus.outSetNo};
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_element actual=%0h required=none", act);
            end else begin
                check("element", 32'(act), 32'(sbQ[0]));
                if (curMode == 1 && sbQ[0].elem == 4'd3 && sbQ[0].vec == 4'd2)
                    check("neg_3_2", 32'(bus.outData), 32'hFFFF_FFE9);
                if (enable && bus.outReady) void'(sbQ.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        enable          = 1'b1;
        bus.inReady     = 1'b0;
        bus.vectorSetNo = 1'b0;
        bus.sumIn       = '0;
        bus.outReady    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outValid", 32'(bus.outValid), 0);
        check("rst_inFull",   32'(bus.inFull),   0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_outElem",  32'(bus.outElem),  0);
        check("rst_outVec",   32'(bus.outVec),   0);
        check("rst_outLast",  32'(bus.outLast),  0);
        reset = 1'b0;
        tick();

        // Single matrix, free-flowing output
        curMode      = 0;
        bus.outReady = 1'b1;
        check("pre_valid", 32'(bus.outValid), 0);
        sendMatrix(0, 0, 1'b0, 1'b1);
        check("latency_valid", 32'(bus.outValid), 1);
        drain(1'b0);
        check("idle_after_single", 32'(bus.outValid), 0);

        // Backpressure 1,0,0,1 with negative data
        curMode      = 1;
        bus.outReady = 1'b0;
        sendMatrix(1, 0, 1'b1, 1'b1);
        drain(1'b1);
        check("idle_after_bp", 32'(bus.outValid), 0);

        // Fill both banks, third matrix dropped
        curMode      = 2;
        bus.outReady = 1'b0;
        sendMatrix(2, 0, 1'b0, 1'b1);
        check("one_not_full", 32'(bus.inFull), 0);
        sendMatrix(2, 1, 1'b1, 1'b1);
        check("two_full",        32'(bus.inFull),   1);
        check("two_no_overflow", 32'(bus.overflow), 0);
        sendMatrix(2, 2, 1'b0, 1'b0);
        check("drop_overflow", 32'(bus.overflow), 1);
        check("drop_full",     32'(bus.inFull),   1);
        bus.outReady = 1'b1;
        drain(1'b0);
        check("overflow_sticky", 32'(bus.overflow), 1);
        check("drained_not_full", 32'(bus.inFull), 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("overflow_cleared", 32'(bus.overflow), 0);

        // Capture coincident with final transfer while full
        curMode      = 2;
        bus.outReady = 1'b0;
        sendMatrix(2, 3, 1'b0, 1'b1);
        sendMatrix(2, 4, 1'b1, 1'b1);
        bus.outReady = 1'b1;
        begin
            int c = 0;
            while (!(bus.outValid && bus.outLast)) begin
                if (c >= 300) begin
                    total++;
                    bad++;
                    $display("FAIL wait_last timeout actual=%0d required=last", c);
                    break;
                end
                tick();
                c++;
            end
        end
        sendMatrix(2, 5, 1'b0, 1'b1);
        check("coincide_full",        32'(bus.inFull),   1);
        check("coincide_no_overflow", 32'(bus.overflow), 0);
        drain(1'b0);
        check("coincide_overflow_end", 32'(bus.overflow), 0);

        // enable low for 5 cycles at (7,4)
        curMode      = 0;
        bus.outReady = 1'b1;
        sendMatrix(0, 0, 1'b1, 1'b1);
        begin
            int c = 0;
            while (!(bus.outVec == 4'd4 && bus.outElem == 4'd7)) begin
                if (c >= 300) begin
                    total++;
                    bad++;
                    $display("FAIL wait_7_4 timeout actual=%0d required=reached", c);
                    break;
                end
                tick();
                c++;
            end
        end
        enable          = 1'b0;
        bus.sumIn       = buildMatrix(2, 6);
        bus.vectorSetNo = 1'b0;
        bus.inReady     = 1'b1;
        repeat (5) tick();
        check("frozen_elem",   32'(bus.outElem),  7);
        check("frozen_vec",    32'(bus.outVec),   4);
        check("frozen_valid",  32'(bus.outValid), 1);
        check("frozen_inFull", 32'(bus.inFull),   0);
        bus.inReady = 1'b0;
        enable      = 1'b1;
        drain(1'b0);
        check("ignored_capture", 32'(bus.outValid), 0);

        // Asynchronous reset mid-matrix
        curMode      = 0;
        bus.outReady = 1'b1;
        sendMatrix(0, 0, 1'b1, 1'b1);
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(bus.outValid), 0);
        check("async_elem",  32'(bus.outElem),  0);
        check("async_vec",   32'(bus.outVec),   0);
        sbQ.delete();
        tick();
        reset = 1'b0;
        check("post_rst_full", 32'(bus.inFull), 0);
        curMode = 1;
        sendMatrix(1, 0, 1'b0, 1'b1);
        check("restart_valid", 32'(bus.outValid), 1);
        check("restart_elem",  32'(bus.outElem),  0);
        check("restart_vec",   32'(bus.outVec),   0);
        drain(1'b0);
        check("final_idle", 32'(bus.outValid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
